// File: rtl/wb_present_pkg.sv
// Shared types for the PRESENT Wishbone register bank: register kinds, bit indices,
// FSM encoding and word-offset helpers for the register map.
package wb_present_pkg;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    typedef enum logic [2:0] {
        RegNone,
        RegKey,
        RegPt,
        RegCt,
        RegCtrl,
        RegStatus
    } reg_kind_e;

    localparam int unsigned CtrlStart  = 0;
    localparam int unsigned CtrlIrqEna = 1;
    localparam int unsigned StatBusy   = 0;
    localparam int unsigned StatDone   = 1;
    localparam int unsigned StatWerr   = 2;

    function automatic int unsigned key_off(int unsigned k);
        return k;
    endfunction

    function automatic int unsigned pt_off(int unsigned kw, int unsigned d);
        return kw + d;
    endfunction

    function automatic int unsigned ct_off(int unsigned kw, int unsigned dw, int unsigned d);
        return kw + dw + d;
    endfunction

    function automatic int unsigned ctrl_off(int unsigned kw, int unsigned dw);
        return kw + 2 * dw;
    endfunction

    function automatic int unsigned status_off(int unsigned kw, int unsigned dw);
        return kw + 2 * dw + 1;
    endfunction

endpackage

// File: rtl/wb_present_addr_dec.sv
// Combinational address decoder: byte address -> register kind, index within that
// kind, and error flag (misaligned, unmapped, or illegal write target).
module wb_present_addr_dec
    import wb_present_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned KEY_WORDS  = 3,
    parameter int unsigned DATA_WORDS = 2
) (
    input  logic [31:0] adr_i,
    input  logic        we_i,
    input  logic        sel0_i,
    input  logic        dat0_i,
    output reg_kind_e   kind_o,
    output logic [31:0] idx_o,
    output logic        err_o
);

    logic [31:0] offset;
    logic [31:0] word;

    // BASE_ADDR is word aligned, so the offset's low bits are the address's low bits.
    assign offset = adr_i - BASE_ADDR;
    assign word   = {2'b00, offset[31:2]};

    always_comb begin
        kind_o = RegNone;
        idx_o  = '0;
        err_o  = 1'b0;
        if (word < pt_off(KEY_WORDS, 0)) begin
            kind_o = RegKey;
            idx_o  = word - key_off(0);
        end else if (word < ct_off(KEY_WORDS, DATA_WORDS, 0)) begin
            kind_o = RegPt;
            idx_o  = word - pt_off(KEY_WORDS, 0);
        end else if (word < ctrl_off(KEY_WORDS, DATA_WORDS)) begin
            kind_o = RegCt;
            idx_o  = word - ct_off(KEY_WORDS, DATA_WORDS, 0);
        end else if (word == ctrl_off(KEY_WORDS, DATA_WORDS)) begin
            kind_o = RegCtrl;
        end else if (word == status_off(KEY_WORDS, DATA_WORDS)) begin
            kind_o = RegStatus;
        end

        if (offset[1:0] != 2'b00 || kind_o == RegNone) begin
            err_o = 1'b1;
        end
        if (we_i && kind_o == RegCt) begin
            err_o = 1'b1;
        end
        // Attempting to set the read-only BUSY bit is rejected.
        if (we_i && kind_o == RegStatus && sel0_i && dat0_i) begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/wb_present_regbank.sv
// Wishbone-classic register bank for the PRESENT core: key/plaintext storage, start
// handshake, ciphertext capture. Define WB_PRESENT_IRQ_EN to add irq_o and CTRL.IRQ_ENA.
module wb_present_regbank
    import wb_present_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned KEY_WORDS  = 3,
    parameter int unsigned DATA_WORDS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [3:0]                 wb_sel_i,
    input  logic [31:0]                wb_adr_i,
    input  logic [31:0]                wb_dat_i,
    output logic [31:0]                wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       wb_stall_o,
    output logic [32*KEY_WORDS-1:0]    key_o,
    output logic [32*DATA_WORDS-1:0]   pt_o,
    output logic                       start_o,
    input  logic                       core_done_i,
    input  logic [32*DATA_WORDS-1:0]   ct_i
`ifdef WB_PRESENT_IRQ_EN
    ,
    output logic                       irq_o
`endif
);

    logic [KEY_WORDS-1:0][31:0]  key_q, key_d;
    logic [DATA_WORDS-1:0][31:0] pt_q, pt_d;
    logic [DATA_WORDS-1:0][31:0] ct_q, ct_d;
    state_e                      state_q, state_d;
    logic                        done_q, done_d;
    logic                        werr_q, werr_d;
    logic                        start_q, start_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;
    logic                        held_q, held_d;
    logic [31:0]                 dat_q, dat_d;
`ifdef WB_PRESENT_IRQ_EN
    logic                        irq_ena_q, irq_ena_d;
`endif

    reg_kind_e   dec_kind;
    logic [31:0] dec_idx;
    logic        dec_err;
    logic        req;
    logic        wr_ok;
    logic        rd_ok;
    logic        busy;

    wb_present_addr_dec #(
        .BASE_ADDR (BASE_ADDR),
        .KEY_WORDS (KEY_WORDS),
        .DATA_WORDS(DATA_WORDS)
    ) u_addr_dec (
        .adr_i (wb_adr_i),
        .we_i  (wb_we_i),
        .sel0_i(wb_sel_i[0]),
        .dat0_i(wb_dat_i[StatBusy]),
        .kind_o(dec_kind),
        .idx_o (dec_idx),
        .err_o (dec_err)
    );

    // held_q blocks a second response while the master keeps the same strobe up.
    assign req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q & ~held_q;
    assign held_d = wb_cyc_i & wb_stb_i & (held_q | req);
    assign wr_ok  = req & wb_we_i & ~dec_err;
    assign rd_ok  = req & ~wb_we_i & ~dec_err;
    assign busy   = (state_q == StBusy);

    always_comb begin
        key_d   = key_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        state_d = state_q;
        done_d  = done_q;
        werr_d  = werr_q;
        start_d = 1'b0;
        ack_d   = req & ~dec_err;
        err_d   = req & dec_err;
        dat_d   = '0;
`ifdef WB_PRESENT_IRQ_EN
        irq_ena_d = irq_ena_q;
`endif

        if (rd_ok) begin
            unique case (dec_kind)
                RegKey: begin
                    for (int unsigned k = 0; k < KEY_WORDS; k++) begin
                        if (dec_idx == k) dat_d = key_q[k];
                    end
                end
                RegPt: begin
                    for (int unsigned d = 0; d < DATA_WORDS; d++) begin
                        if (dec_idx == d) dat_d = pt_q[d];
                    end
                end
                RegCt: begin
                    for (int unsigned d = 0; d < DATA_WORDS; d++) begin
                        if (dec_idx == d) dat_d = ct_q[d];
                    end
                end
                RegCtrl: begin
`ifdef WB_PRESENT_IRQ_EN
                    dat_d[CtrlIrqEna] = irq_ena_q;
`endif
                end
                RegStatus: begin
                    dat_d[StatBusy] = busy;
                    dat_d[StatDone] = done_q;
                    dat_d[StatWerr] = werr_q;
                end
                default: ;
            endcase
        end

        if (wr_ok) begin
            unique case (dec_kind)
                RegKey: begin
                    if (busy) begin
                        werr_d = 1'b1;
                    end else begin
                        for (int unsigned k = 0; k < KEY_WORDS; k++) begin
                            for (int unsigned b = 0; b < 4; b++) begin
                                if (dec_idx == k && wb_sel_i[b]) begin
                                    key_d[k][8*b+:8] = wb_dat_i[8*b+:8];
                                end
                            end
                        end
                    end
                end
                RegPt: begin
                    if (busy) begin
                        werr_d = 1'b1;
                    end else begin
                        for (int unsigned d = 0; d < DATA_WORDS; d++) begin
                            for (int unsigned b = 0; b < 4; b++) begin
                                if (dec_idx == d && wb_sel_i[b]) begin
                                    pt_d[d][8*b+:8] = wb_dat_i[8*b+:8];
                                end
                            end
                        end
                    end
                end
                RegCtrl: begin
                    if (wb_sel_i[0]) begin
                        if (wb_dat_i[CtrlStart] && !busy) begin
                            state_d = StBusy;
                            start_d = 1'b1;
                            done_d  = 1'b0;
                        end
`ifdef WB_PRESENT_IRQ_EN
                        irq_ena_d = wb_dat_i[CtrlIrqEna];
`endif
                    end
                end
                RegStatus: begin
                    if (wb_sel_i[0]) begin
                        if (wb_dat_i[StatDone]) done_d = 1'b0;
                        if (wb_dat_i[StatWerr]) werr_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Placed last so a completion beats a same-cycle W1C of DONE.
        if (busy && core_done_i) begin
            ct_d    = ct_i;
            done_d  = 1'b1;
            state_d = StDone;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            state_q <= StIdle;
            done_q  <= 1'b0;
            werr_q  <= 1'b0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            held_q  <= 1'b0;
            dat_q   <= '0;
`ifdef WB_PRESENT_IRQ_EN
            irq_ena_q <= 1'b0;
`endif
        end else begin
            key_q   <= key_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            state_q <= state_d;
            done_q  <= done_d;
            werr_q  <= werr_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            held_q  <= held_d;
            dat_q   <= dat_d;
`ifdef WB_PRESENT_IRQ_EN
            irq_ena_q <= irq_ena_d;
`endif
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_stall_o = 1'b0;
    assign key_o      = key_q;
    assign pt_o       = pt_q;
    assign start_o    = start_q;
`ifdef WB_PRESENT_IRQ_EN
    assign irq_o = done_q & irq_ena_q;
`endif

endmodule

// File: tb/tb_wb_present_regbank.sv
// Self-checking bench for wb_present_regbank: vector table plus hand-written sequences,
// with bus responses checked against a queue of expectations.
module tb_wb_present_regbank;

    localparam logic [31:0] Base  = 32'h3000_0000;
    localparam logic [31:0] AKey0 = Base + 32'h00;
    localparam logic [31:0] AKey1 = Base + 32'h04;
    localparam logic [31:0] AKey2 = Base + 32'h08;
    localparam logic [31:0] APt0  = Base + 32'h0C;
    localparam logic [31:0] APt1  = Base + 32'h10;
    localparam logic [31:0] ACt0  = Base + 32'h14;
    localparam logic [31:0] ACt1  = Base + 32'h18;
    localparam logic [31:0] ACtrl = Base + 32'h1C;
    localparam logic [31:0] AStat = Base + 32'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_stall_o;
    logic [95:0] key_o;
    logic [63:0] pt_o;
    logic        start_o;
    logic        core_done_i;
    logic [63:0] ct_i;
`ifdef WB_PRESENT_IRQ_EN
    logic        irq_o;
`endif

    wb_present_regbank dut (
        .clk        (clk),
        .reset      (reset),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_stall_o (wb_stall_o),
        .key_o      (key_o),
        .pt_o       (pt_o),
        .start_o    (start_o),
        .core_done_i(core_done_i),
        .ct_i       (ct_i)
`ifdef WB_PRESENT_IRQ_EN
        ,
        .irq_o      (irq_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          err;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          err;
        bit          chk_dat;
        logic [31:0] dat;
        int          id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   xfer_id = 0;
    int   start_cnt = 0;

    task automatic check(input string name, input int id, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %0h, want %0h", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start_o) start_cnt++;
    end

    // Scoreboard: every ack/err pops one expectation.
    always @(negedge clk) begin
        if (wb_ack_o || wb_err_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b, want no response",
                         wb_ack_o, wb_err_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp", e.id, 128'({wb_ack_o, wb_err_o}), 128'(e.err ? 2'b01 : 2'b10));
                if (e.chk_dat) check("rdata", e.id, 128'(wb_dat_o), 128'(e.dat));
            end
        end
    end

    task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit exp_err, input logic [31:0] exp_dat);
        int waited;
        exp_t e;
        xfer_id++;
        e.err     = exp_err;
        e.chk_dat = !we || exp_err;
        e.dat     = exp_err ? 32'h0 : exp_dat;
        e.id      = xfer_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = dat;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(wb_ack_o || wb_err_o) && waited < 8);
        check("latency", xfer_id, 128'(waited), 128'(2));
        if (!(wb_ack_o || wb_err_o)) void'(sb.pop_back());
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp_dat);
        xfer(1'b0, adr, 4'hF, 32'h0, 1'b0, exp_dat);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        xfer(1'b1, adr, 4'hF, dat, 1'b0, 32'h0);
    endtask

    task automatic pulse_done(input logic [63:0] ct);
        @(posedge clk);
        #1;
        core_done_i = 1'b1;
        ct_i        = ct;
        @(posedge clk);
        #1;
        core_done_i = 1'b0;
    endtask

    initial begin
        int s0;
        int acks;
        reset       = 1'b1;
        wb_cyc_i    = 1'b0;
        wb_stb_i    = 1'b0;
        wb_we_i     = 1'b0;
        wb_sel_i    = 4'h0;
        wb_adr_i    = 32'h0;
        wb_dat_i    = 32'h0;
        core_done_i = 1'b0;
        ct_i        = 64'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_start", 0, 128'(start_o), 128'(0));
        check("rst_key", 0, 128'(key_o), 128'(0));
        check("rst_ack_err", 0, 128'({wb_ack_o, wb_err_o, wb_stall_o}), 128'(0));

        //           we    adr         sel    dat            err   exp
        vecs.push_back('{1'b0, AStat,      4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, AKey0,      4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, AKey1,      4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, AKey2,      4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, APt0,       4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, APt1,       4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, ACt0,       4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, ACt1,       4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, ACtrl,      4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, AKey0,      4'b0011, 32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, AKey0,      4'h0, 32'h0,         1'b0, 32'h0000BEEF});
        vecs.push_back('{1'b1, AKey0 + 2,  4'hF, 32'h1,         1'b1, 32'h0});
        vecs.push_back('{1'b0, AKey0 + 2,  4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, Base + 36,  4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, Base - 4,   4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b1, ACt0,       4'hF, 32'h1234,      1'b1, 32'h0});
        vecs.push_back('{1'b1, AStat,      4'h1, 32'h1,         1'b1, 32'h0});
        vecs.push_back('{1'b0, AKey0,      4'hF, 32'h0,         1'b0, 32'h0000BEEF});
        vecs.push_back('{1'b1, AKey1,      4'h0, 32'hFFFFFFFF,  1'b0, 32'h0});
        vecs.push_back('{1'b0, AKey1,      4'hF, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, AKey1,      4'b1100, 32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{1'b0, AKey1,      4'hF, 32'h0,         1'b0, 32'h12340000});
        vecs.push_back('{1'b1, AKey0,      4'hF, 32'h01234567,  1'b0, 32'h0});
        vecs.push_back('{1'b1, AKey1,      4'hF, 32'h55AA55AA,  1'b0, 32'h0});
        vecs.push_back('{1'b1, AKey2,      4'hF, 32'h89ABCDEF,  1'b0, 32'h0});
        vecs.push_back('{1'b1, APt0,       4'hF, 32'h11111111,  1'b0, 32'h0});
        vecs.push_back('{1'b1, APt1,       4'hF, 32'h22222222,  1'b0, 32'h0});
        vecs.push_back('{1'b0, AStat,      4'hF, 32'h0,         1'b0, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].err, vecs[i].exp);
        end
        check("key_o", 0, 128'(key_o), 128'({32'h89ABCDEF, 32'h55AA55AA, 32'h01234567}));
        check("pt_o", 0, 128'(pt_o), 128'({32'h22222222, 32'h11111111}));

        // Held strobe: exactly one response.
        xfer_id++;
        sb.push_back('{1'b0, 1'b1, 32'h01234567, xfer_id});
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = AKey0;
        acks     = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        check("held_acks", xfer_id, 128'(acks), 128'(1));
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        // Start, complete, read ciphertext.
        s0 = start_cnt;
        wr(ACtrl, 32'h1);
        repeat (2) @(negedge clk);
        check("start_pulse", 0, 128'(start_cnt - s0), 128'(1));
        rd(AStat, 32'h1);
        pulse_done(64'h5579C1387B228445);
        rd(AStat, 32'h2);
        rd(ACt0, 32'h7B228445);
        rd(ACt1, 32'h5579C138);
        rd(ACtrl, 32'h0);

        // Writes and START during BUSY.
        s0 = start_cnt;
        wr(ACtrl, 32'h1);
        rd(AStat, 32'h1);
        wr(APt0, 32'h1);
        rd(APt0, 32'h11111111);
        rd(AStat, 32'h5);
        wr(AStat, 32'h6);
        rd(AStat, 32'h1);
        wr(ACtrl, 32'h1);
        repeat (2) @(negedge clk);
        check("start_busy", 0, 128'(start_cnt - s0), 128'(1));

        // Reset in the middle of BUSY, then a stray completion.
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pulse_done(64'hCAFEF00D12345678);
        rd(AStat, 32'h0);
        rd(ACt0, 32'h0);
        rd(ACt1, 32'h0);
        rd(AKey0, 32'h0);

`ifdef WB_PRESENT_IRQ_EN
        wr(ACtrl, 32'h3);
        rd(ACtrl, 32'h2);
        @(negedge clk);
        check("irq_busy", 0, 128'(irq_o), 128'(0));
        pulse_done(64'h0123456789ABCDEF);
        @(negedge clk);
        check("irq_set", 0, 128'(irq_o), 128'(1));
        wr(AStat, 32'h2);
        @(negedge clk);
        check("irq_clr", 0, 128'(irq_o), 128'(0));
        rd(AStat, 32'h0);
`else
        wr(ACtrl, 32'h2);
        rd(ACtrl, 32'h0);
        rd(AStat, 32'h0);
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 0, 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
